// File: rtl/mmio_pkg.sv
// Register map and STATUS layout for MMIO peripherals on the CPU data bus.
package mmio_pkg;

  // Byte offsets inside a 16-byte register window; only bits [3:2] decode.
  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_DIV    = 4'h8;
  localparam logic [3:0] REG_RSVD   = 4'hC;

  // STATUS register bit positions.
  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count, so a push while full is
  // refused even when a pop happens in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV registers, TX FIFO, shifter.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_4000,
  parameter logic [15:0] CLKS_PER_BIT = 16'd16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic [3:0]  wr_strobe,
  input  logic        rd_strobe,
  output logic [31:0] data_out,
  output logic        txd,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state, state_next;
  logic          hit, bus_wr, bus_rd, push, pop, load, tick, txd_next;
  logic [1:0]    sel;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_rdata;
  logic [15:0]   div, div_eff, reload, timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          ovf;
  logic [31:0]   status_word;
  logic          unused_bits;

  assign unused_bits = ^{addr[1:0], data_in[31:16]};

  assign hit    = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel    = addr[3:2];
  assign bus_wr = hit && (wr_strobe != '0);
  assign bus_rd = hit && rd_strobe;
  assign push   = bus_wr && (sel == REG_DATA[3:2]) && wr_strobe[0];

  assign div_eff = (div == '0) ? 16'd1 : div;
  assign tick    = (timer == '0);

  always_comb begin
    status_word                              = '0;
    status_word[ST_BUSY]                     = (state != IDLE);
    status_word[ST_FULL]                     = fifo_full;
    status_word[ST_EMPTY]                    = fifo_empty;
    status_word[ST_OVF]                      = ovf;
    status_word[ST_COUNT_LSB +: 3]           = 3'(fifo_count);
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (data_in[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bus side: registered read data, sticky overflow flag, divisor register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      ovf      <= 1'b0;
      div      <= CLKS_PER_BIT;
    end else begin
      if (bus_rd) begin
        unique case (sel)
          REG_STATUS[3:2]: data_out <= status_word;
          REG_DIV[3:2]:    data_out <= {16'h0000, div};
          default:         data_out <= '0;
        endcase
      end
      // A read of STATUS clears OVF after capture; a new overflow wins.
      if (bus_rd && sel == REG_STATUS[3:2]) ovf <= 1'b0;
      if (push && fifo_full)                ovf <= 1'b1;
      if (bus_wr && sel == REG_DIV[3:2]) begin
        if (wr_strobe[0]) div[7:0]  <= data_in[7:0];
        if (wr_strobe[1]) div[15:8] <= data_in[15:8];
      end
    end
  end

  // Shifter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state, FIFO pop and frame load; STOP chains straight into START when
  // another byte is waiting so back-to-back frames have no idle gap.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    txd_next   = 1'b1;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        txd_next = 1'b0;
        if (tick) state_next = DATA;
      end
      DATA: begin
        txd_next = shreg[bit_idx];
        if (tick && bit_idx == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (tick) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            load       = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit timer, bit index, shift data and registered line/interrupt outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload  <= '0;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
      irq     <= 1'b1;
    end else begin
      if (load) begin
        reload  <= div_eff;
        timer   <= div_eff - 16'd1;
        bit_idx <= '0;
        shreg   <= fifo_rdata;
      end else if (state != IDLE) begin
        if (tick) begin
          timer <= reload - 16'd1;
          if (state == DATA) bit_idx <= bit_idx + 3'd1;
        end else begin
          timer <= timer - 16'd1;
        end
      end
      txd <= txd_next;
      irq <= (state == IDLE) && fifo_empty;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register table plus serial-frame sequences.
module tb_mmio_uart_tx;

  localparam logic [31:0] B = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [3:0]  wr_strobe;
  logic        rd_strobe;
  logic [31:0] data_out;
  logic        txd;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR    (B),
    .CLKS_PER_BIT (16'd16),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_in   (data_in),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .data_out  (data_out),
    .txd       (txd),
    .irq       (irq)
  );

  // One sample of txd/irq per clock cycle, taken on the falling edge.
  bit   rec_en = 1'b0;
  logic txq[$];
  logic irqq[$];
  always @(negedge clk) begin
    if (rec_en) begin
      txq.push_back(txd);
      irqq.push_back(irq);
    end
  end

  typedef struct {
    bit          is_rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[21];

  logic [7:0] fb[4];
  int         fd[4];
  int         nf;
  int         end_pos;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    addr = a; data_in = d; wr_strobe = s;
    @(posedge clk);
    #1 wr_strobe = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
    @(negedge clk);
    addr = a; rd_strobe = 1'b1;
    @(posedge clk);
    #1 rd_strobe = 1'b0;
    r = data_out;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (irq !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    chk("idle wait", {31'd0, irq}, 32'd1);
  endtask

  // Compares the recorded txd trace against nf frames described by fb/fd,
  // starting at the first low sample at or after index start.
  task automatic check_trace(input string name, input int start, input int lat);
    int         f = -1;
    int         pos;
    int         mism;
    logic [7:0] bv;
    logic       eb;
    for (int i = start; i < txq.size(); i++) begin
      if (txq[i] === 1'b0) begin
        f = i;
        break;
      end
    end
    if (f < 0) begin
      checks++;
      errors++;
      $display("FAIL %s start: got no start bit expected start bit", name);
      end_pos = -1;
      return;
    end
    if (lat >= 0) chk({name, " latency"}, 32'(f - start), 32'(lat));
    pos = f;
    for (int k = 0; k < nf; k++) begin
      mism = 0;
      bv = fb[k];
      for (int b = 0; b < 10; b++) begin
        eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bv[b-1];
        for (int c = 0; c < fd[k]; c++) begin
          if (pos >= txq.size() || txq[pos] !== eb) mism++;
          pos++;
        end
      end
      chk($sformatf("%s frame%0d bad samples", name, k), 32'(mism), 32'd0);
    end
    end_pos = pos;
    chk({name, " line idle after"}, {31'd0, (pos < txq.size()) ? txq[pos] : 1'bx}, 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    int          start;

    rst = 1'b0; addr = '0; data_in = '0; wr_strobe = '0; rd_strobe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset txd", {31'd0, txd}, 32'd1);
    chk("reset irq", {31'd0, irq}, 32'd1);
    chk("reset data_out", data_out, 32'd0);

    // Start a frame of zeros with more bytes queued, then reset mid-frame.
    bus_write(B + 32'h8, 32'd5, 4'h3);
    bus_write(B + 32'h0, 32'h00, 4'h1);
    bus_write(B + 32'h0, 32'h11, 4'h1);
    bus_write(B + 32'h0, 32'h22, 4'h1);
    repeat (8) @(posedge clk);
    #3;
    chk("mid-frame txd low", {31'd0, txd}, 32'd0);
    rst = 1'b0;
    #1;
    chk("async reset txd", {31'd0, txd}, 32'd1);
    chk("async reset irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Register access table; entries 15..20 cover decode and strobe corners.
    tbl[0]  = '{1'b1, B + 32'h4,  32'h0,         4'h0, 32'h4};
    tbl[1]  = '{1'b1, B + 32'h8,  32'h0,         4'h0, 32'd16};
    tbl[2]  = '{1'b1, B + 32'h0,  32'h0,         4'h0, 32'h0};
    tbl[3]  = '{1'b1, B + 32'h9,  32'h0,         4'h0, 32'd16};
    tbl[4]  = '{1'b1, B + 32'hC,  32'h0,         4'h0, 32'h0};
    tbl[5]  = '{1'b0, B + 32'h8,  32'h0001_2345, 4'hF, 32'h0};
    tbl[6]  = '{1'b1, B + 32'h8,  32'h0,         4'h0, 32'h2345};
    tbl[7]  = '{1'b0, B + 32'h8,  32'h0000_AB77, 4'h1, 32'h0};
    tbl[8]  = '{1'b1, B + 32'h8,  32'h0,         4'h0, 32'h2377};
    tbl[9]  = '{1'b0, B + 32'h8,  32'h0000_8800, 4'h2, 32'h0};
    tbl[10] = '{1'b1, B + 32'h8,  32'h0,         4'h0, 32'h8877};
    tbl[11] = '{1'b0, B + 32'hC,  32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[12] = '{1'b1, B + 32'hC,  32'h0,         4'h0, 32'h0};
    tbl[13] = '{1'b0, B + 32'h8,  32'h0000_0010, 4'h3, 32'h0};
    tbl[14] = '{1'b1, B + 32'h8,  32'h0,         4'h0, 32'd16};
    tbl[15] = '{1'b0, B + 32'h10, 32'h55,        4'h1, 32'h0};
    tbl[16] = '{1'b1, B + 32'h4,  32'h0,         4'h0, 32'h4};
    tbl[17] = '{1'b1, B + 32'h14, 32'h0,         4'h0, 32'h4};
    tbl[18] = '{1'b1, 32'h0000_0008, 32'h0,      4'h0, 32'h4};
    tbl[19] = '{1'b0, B + 32'h0,  32'h77,        4'h2, 32'h0};
    tbl[20] = '{1'b1, B + 32'h4,  32'h0,         4'h0, 32'h4};

    for (int i = 0; i < 21; i++) begin
      if (tbl[i].is_rd) begin
        bus_read(tbl[i].a, r);
        chk($sformatf("table read %0d @0x%0h", i, tbl[i].a), r, tbl[i].exp);
      end else begin
        bus_write(tbl[i].a, tbl[i].d, tbl[i].s);
      end
    end
    chk("irq after table", {31'd0, irq}, 32'd1);

    rec_en = 1'b1;

    // Single byte 0xA5 at DIV=4.
    bus_write(B + 32'h8, 32'd4, 4'h3);
    bus_write(B + 32'h0, 32'hA5, 4'h1);
    start = txq.size();
    repeat (60) @(posedge clk);
    nf = 1; fb[0] = 8'hA5; fd[0] = 4;
    check_trace("single", start, 2);
    if (end_pos > 0 && end_pos < irqq.size()) begin
      chk("irq low in last stop cycle", {31'd0, irqq[end_pos-1]}, 32'd0);
      chk("irq high after stop", {31'd0, irqq[end_pos]}, 32'd1);
    end

    // FIFO fill and overflow at DIV=100.
    bus_write(B + 32'h8, 32'd100, 4'h3);
    for (int i = 0; i < 6; i++) bus_write(B + 32'h0, 32'(8'h10 + i), 4'h1);
    bus_read(B + 32'h4, r);
    chk("overflow status", r & 32'hFFFF_FFFE, 32'h4A);
    chk("overflow busy", {31'd0, r[0]}, 32'd1);
    bus_read(B + 32'h4, r);
    chk("ovf cleared status", r & 32'hFFFF_FFFE, 32'h42);
    chk("ovf cleared busy", {31'd0, r[0]}, 32'd1);
    do_reset();

    // Back-to-back frames 0x00, 0xFF at DIV=2.
    bus_write(B + 32'h8, 32'd2, 4'h3);
    bus_write(B + 32'h0, 32'h00, 4'h1);
    start = txq.size();
    bus_write(B + 32'h0, 32'hFF, 4'h1);
    repeat (60) @(posedge clk);
    nf = 2; fb[0] = 8'h00; fd[0] = 2; fb[1] = 8'hFF; fd[1] = 2;
    check_trace("b2b", start, 2);
    wait_idle(50);

    // DIV change during DATA: 80-clock frame, then 30-clock frame.
    bus_write(B + 32'h8, 32'd8, 4'h3);
    bus_write(B + 32'h0, 32'h3C, 4'h1);
    start = txq.size();
    repeat (25) @(posedge clk);
    bus_write(B + 32'h8, 32'd3, 4'h3);
    bus_write(B + 32'h0, 32'hC3, 4'h1);
    repeat (120) @(posedge clk);
    nf = 2; fb[0] = 8'h3C; fd[0] = 8; fb[1] = 8'hC3; fd[1] = 3;
    check_trace("divchg", start, 2);
    wait_idle(100);

    // DIV=0 behaves as one clock per bit.
    bus_write(B + 32'h8, 32'd0, 4'h3);
    bus_write(B + 32'h0, 32'h5A, 4'h1);
    start = txq.size();
    repeat (25) @(posedge clk);
    nf = 1; fb[0] = 8'h5A; fd[0] = 1;
    check_trace("div0", start, 2);
    wait_idle(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
